// File: rtl/box_cmd_receiver.sv
// Overlay-box command receiver: parses framed box packets from the RX byte
// stream, validates each slot and presents a double-buffered, self-expiring box set.
module box_cmd_receiver #(
  parameter int          BOX_NUM         = 4,
  parameter int          H_ACT           = 1280,
  parameter int          V_ACT           = 720,
  parameter logic [7:0]  MAGIC           = 8'hA5,
  parameter bit          COMMIT_ON_VSYNC = 1'b1,
  parameter int unsigned STALE_TICKS     = 125_000_000,
  localparam int         XW              = $clog2(H_ACT),
  localparam int         YW              = $clog2(V_ACT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [7:0]            i_data,
  input  logic                  vsync,
  output logic [BOX_NUM*XW-1:0] start_xs,
  output logic [BOX_NUM*YW-1:0] start_ys,
  output logic [BOX_NUM*XW-1:0] end_xs,
  output logic [BOX_NUM*YW-1:0] end_ys,
  output logic [BOX_NUM*24-1:0] colors,
  output logic [BOX_NUM-1:0]    box_en,
  output logic                  updated,
  output logic                  pkt_err,
  output logic [15:0]           err_cnt
);

  // state | meaning
  // IDLE  | waiting for the first byte of a packet (MAGIC check)
  // COUNT | next byte is the box count N
  // BODY  | record bytes, written into the shadow bank while slot_idx < N
  // DROP  | packet already rejected, swallow bytes until valid falls
  typedef enum logic [1:0] {IDLE, COUNT, BODY, DROP} state_t;

  localparam int         SW    = (BOX_NUM > 1) ? $clog2(BOX_NUM) : 1;
  localparam logic [7:0] BOX_B = 8'(BOX_NUM);

  state_t      state;
  logic        valid_q;
  logic        vsync_q;
  logic [15:0] byte_cnt;
  logic [7:0]  n_lat;
  logic [7:0]  slot_idx;
  logic [3:0]  byte_idx;
  logic        hdr_ok;
  logic        wr_bank;
  logic        pend_bank;
  logic        pending;
  logic        stale_armed;
  logic [31:0] stale_cnt;
  logic [7:0]  bank_n [2];
  logic [7:0]  shadow [2][BOX_NUM][11];

  logic        pkt_end;
  logic        accept;
  logic        reject;
  logic [15:0] exp_cnt;
  logic        commit_bank;
  logic [7:0]  commit_n;
  logic        do_commit;
  logic        stale_fire;

  logic [15:0]        sx_c  [BOX_NUM];
  logic [15:0]        sy_c  [BOX_NUM];
  logic [15:0]        ex_c  [BOX_NUM];
  logic [15:0]        ey_c  [BOX_NUM];
  logic [23:0]        col_c [BOX_NUM];
  logic [BOX_NUM-1:0] ok_c;

  assign pkt_end = valid_q & ~valid;
  assign exp_cnt = 16'd2 + 16'd11 * {8'd0, n_lat};
  assign accept  = pkt_end & hdr_ok & (byte_cnt == exp_cnt);
  assign reject  = pkt_end & ~accept;

  // Immediate mode commits straight from the bank just filled; vsync mode
  // commits from the bank parked at accept time.
  assign commit_bank = COMMIT_ON_VSYNC ? pend_bank : wr_bank;
  assign commit_n    = COMMIT_ON_VSYNC ? bank_n[pend_bank] : n_lat;
  assign do_commit   = COMMIT_ON_VSYNC ? (pending & vsync & ~vsync_q & ~accept) : accept;
  assign stale_fire  = stale_armed & (stale_cnt == 32'd1) & ~accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      byte_cnt <= '0;
      n_lat    <= '0;
      slot_idx <= '0;
      byte_idx <= '0;
      hdr_ok   <= 1'b0;
      wr_bank  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_n[b] <= '0;
        for (int s = 0; s < BOX_NUM; s++)
          for (int i = 0; i < 11; i++)
            shadow[b][s][i] <= '0;
      end
    end else begin
      valid_q <= valid;
      if (pkt_end) begin
        state    <= IDLE;
        byte_cnt <= '0;
        hdr_ok   <= 1'b0;
        if (accept) begin
          bank_n[wr_bank] <= n_lat;
          wr_bank         <= ~wr_bank;
        end
      end else if (valid) begin
        if (byte_cnt != 16'hFFFF)
          byte_cnt <= byte_cnt + 16'd1;
        case (state)
          IDLE: begin
            hdr_ok <= 1'b0;
            state  <= (i_data == MAGIC) ? COUNT : DROP;
          end
          COUNT: begin
            n_lat    <= i_data;
            slot_idx <= '0;
            byte_idx <= '0;
            if (i_data > BOX_B) begin
              hdr_ok <= 1'b0;
              state  <= DROP;
            end else begin
              // N == 0 also lands here; no slot is writable so BODY just waits for the end
              hdr_ok <= 1'b1;
              state  <= BODY;
            end
          end
          BODY: begin
            if (slot_idx < n_lat) begin
              shadow[wr_bank][slot_idx[SW-1:0]][byte_idx] <= i_data;
              if (byte_idx == 4'd10) begin
                byte_idx <= '0;
                slot_idx <= slot_idx + 8'd1;
              end else begin
                byte_idx <= byte_idx + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ok_c = '0;
    for (int k = 0; k < BOX_NUM; k++) begin
      sx_c[k]  = {shadow[commit_bank][k][0], shadow[commit_bank][k][1]};
      sy_c[k]  = {shadow[commit_bank][k][2], shadow[commit_bank][k][3]};
      ex_c[k]  = {shadow[commit_bank][k][4], shadow[commit_bank][k][5]};
      ey_c[k]  = {shadow[commit_bank][k][6], shadow[commit_bank][k][7]};
      col_c[k] = {shadow[commit_bank][k][8], shadow[commit_bank][k][9],
                  shadow[commit_bank][k][10]};
      ok_c[k]  = (8'(k) < commit_n)
               && ((sx_c[k] >> XW) == 16'd0) && ((ex_c[k] >> XW) == 16'd0)
               && ((sy_c[k] >> YW) == 16'd0) && ((ey_c[k] >> YW) == 16'd0)
               && (sx_c[k] <= ex_c[k]) && (ex_c[k] < 16'(H_ACT))
               && (sy_c[k] <= ey_c[k]) && (ey_c[k] < 16'(V_ACT));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      pend_bank   <= 1'b0;
      pending     <= 1'b0;
      stale_armed <= 1'b0;
      stale_cnt   <= '0;
      updated     <= 1'b0;
      pkt_err     <= 1'b0;
      err_cnt     <= '0;
      start_xs    <= '0;
      start_ys    <= '0;
      end_xs      <= '0;
      end_ys      <= '0;
      colors      <= '0;
      box_en      <= '0;
    end else begin
      vsync_q <= vsync;
      updated <= 1'b0;
      pkt_err <= reject;
      if (reject && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;

      if (accept) begin
        pending   <= COMMIT_ON_VSYNC;
        pend_bank <= wr_bank;
      end else if (do_commit) begin
        pending <= 1'b0;
      end

      // Down-counter reloaded on accept; fires once on terminal count then idles.
      if (accept) begin
        stale_armed <= (STALE_TICKS != 0);
        stale_cnt   <= 32'(STALE_TICKS);
      end else if (stale_armed) begin
        if (stale_cnt == 32'd1) begin
          stale_armed <= 1'b0;
          stale_cnt   <= '0;
        end else begin
          stale_cnt <= stale_cnt - 32'd1;
        end
      end

      if (do_commit) begin
        updated <= 1'b1;
        for (int k = 0; k < BOX_NUM; k++) begin
          start_xs[k*XW +: XW] <= ok_c[k] ? sx_c[k][XW-1:0] : '0;
          start_ys[k*YW +: YW] <= ok_c[k] ? sy_c[k][YW-1:0] : '0;
          end_xs[k*XW +: XW]   <= ok_c[k] ? ex_c[k][XW-1:0] : '0;
          end_ys[k*YW +: YW]   <= ok_c[k] ? ey_c[k][YW-1:0] : '0;
          colors[k*24 +: 24]   <= ok_c[k] ? col_c[k] : '0;
          box_en[k]            <= ok_c[k];
        end
      end else if (stale_fire) begin
        updated  <= 1'b1;
        start_xs <= '0;
        start_ys <= '0;
        end_xs   <= '0;
        end_ys   <= '0;
        colors   <= '0;
        box_en   <= '0;
      end
    end
  end

endmodule
